mem_burst_bridge: RTL and testbench
===================================

Name: mem_burst_bridge

Overview:
- Sits directly downstream of the 2-way L1 cache, between the cache's 128-bit block memory port and the 32-bit word-wide main memory bus.
- Converts each block read or write request from the cache into a burst of four sequential word transfers with per-word handshaking.
- Returns a single one-cycle mem_ready pulse to the cache when the whole block transfer has completed.

Parameters:
- BLK_ADDR_W, 28, block address width (cache-side mem_addr width).
- WORDS, 4, words per block (fixed at 4; counter width is 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- mem_read  input  1  cache block-read request, held until mem_ready.
- mem_write  input  1  cache block-write request, held until mem_ready.
- mem_addr  input  28  block address.
- mem_wdata  input  128  block write data; word k is bits [32k+31:32k].
- mem_rdata  output  128  block read data, same word mapping.
- mem_ready  output  1  one-cycle completion pulse to the cache.
- dram_req  output  1  word transfer request.
- dram_we  output  1  1 = word write, 0 = word read; valid while dram_req is high.
- dram_addr  output  30  word address = {block address, word index[1:0]}.
- dram_wdata  output  32  write word.
- dram_rdata  input  32  read word; valid in the cycle dram_ack is high.
- dram_ack  input  1  word transfer complete; may be asserted in the same cycle dram_req rises.

Behaviour:
- Reset: synchronous on rst_n==0 at a clk edge, and it overrides everything including a burst in progress.
  - State goes to IDLE, cnt=0, addr_q=0, wdata_q=0, op_q=0, rbuf=0.
  - Outputs after reset: mem_ready=0, mem_rdata=0, dram_req=0, dram_we=0, dram_addr=0, dram_wdata=0.
  - A burst aborted by reset is not resumed.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - If mem_read=1, latch addr_q=mem_addr, set cnt=0, go to RD_BURST.
  - Else if mem_write=1, latch addr_q and wdata_q=mem_wdata, set cnt=0, go to WR_BURST.
  - If both are high, read wins (illegal from the cache, but defined).
  - Cache inputs are sampled only in IDLE. Later changes are ignored until the next IDLE.
- RD_BURST / WR_BURST:
  - dram_req=1 continuously, dram_addr={addr_q,cnt}.
  - dram_we=1 in WR_BURST only. dram_wdata=wdata_q[32*cnt+31:32*cnt] in WR_BURST, 0 otherwise.
  - On dram_ack: in RD_BURST, rbuf[32*cnt+31:32*cnt] <= dram_rdata.
  - On dram_ack: if cnt==3, go to DONE; else cnt <= cnt+1. The new address is presented in the next cycle.
  - With no ack, the state holds and all dram outputs stay stable.
- DONE:
  - mem_ready=1 for exactly this cycle, dram_req=0, then go to IDLE.
  - The cache drops its request combinationally on mem_ready, so IDLE in the next cycle sees any fresh request. Example: a write-back followed by a refill costs exactly one IDLE cycle between bursts.
- mem_rdata:
  - Driven from the registered rbuf.
  - Updated only by read bursts and held stable between bursts; a write burst does not change it.
  - Valid at the latest in the DONE cycle.
- Latency with a zero-wait memory (ack in the same cycle as req): request seen in IDLE at cycle T, words at T+1..T+4, mem_ready at T+5. Each memory wait cycle adds one.
- dram_ack while dram_req=0 is ignored.
- cnt wraps from 3 to 0 only through DONE → IDLE; it never wraps inside a burst.
- No combinational path from dram_ack to dram_req, dram_addr or dram_we. Only the state/cnt update depends on it.

Test Plan:
- Reset mid-RD_BURST after 2 acks, rst_n=0 for one cycle → dram_req=0, mem_ready=0, mem_rdata=0 next cycle; no further dram activity until a new mem_read.
- Zero-wait read: mem_read=1, mem_addr=28'h0000012, memory returns word data 32'h11111111 × (index+1) → dram_addr 30'h48,49,4A,4B on consecutive cycles; mem_ready high only at T+5; mem_rdata=128'h44444444_33333333_22222222_11111111.
- Write with waits: mem_write=1, mem_addr=28'h3, mem_wdata=128'hDDDD_CCCC_BBBB_AAAA word-packed, ack after 2 wait cycles per word → dram_we=1, dram_addr 0xC..0xF, words AAAA, BBBB, CCCC, DDDD held stable during waits; mem_ready at T+13; mem_rdata unchanged.
- Write-back then refill, as the cache issues on a dirty miss: mem_write (addr 5), then mem_read (addr 9) asserted the cycle after mem_ready → exactly one IDLE cycle between bursts; read burst uses addresses 0x24..0x27.
- Spurious dram_ack in IDLE, and mem_read+mem_write asserted together → ack ignored; read burst performed with dram_we=0.
- Input change mid-burst: mem_addr changed after the first word → the remaining words still use the latched addr_q.

Source files
------------

// File: rtl/mem_burst_bridge.sv
// Purpose: bridges a 128-bit cache block port to a 32-bit word memory bus as 4-word bursts.
// Latency: request seen in IDLE at T, words at T+1..T+4, mem_ready at T+5 (+1 per memory wait cycle).
// Backpressure: each word is held on the bus until dram_ack; cache request is held until mem_ready.
module mem_burst_bridge #(
  parameter int BLK_ADDR_W = 28,
  parameter int WORDS      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLK_ADDR_W-1:0]   mem_addr,
  input  logic [32*WORDS-1:0]     mem_wdata,
  output logic [32*WORDS-1:0]     mem_rdata,
  output logic                    mem_ready,
  output logic                    dram_req,
  output logic                    dram_we,
  output logic [BLK_ADDR_W+1:0]   dram_addr,
  output logic [31:0]             dram_wdata,
  input  logic [31:0]             dram_rdata,
  input  logic                    dram_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Index of the last word in a block; the burst ends when it is acknowledged.
  localparam logic [1:0] CNT_LAST = 2'(WORDS - 1);

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [BLK_ADDR_W-1:0]   addr_q, addr_d;
  logic [32*WORDS-1:0]     wdata_q, wdata_d;
  logic                    op_q, op_d;     // 1 = block write, 0 = block read
  logic [32*WORDS-1:0]     rbuf_q, rbuf_d;

  logic                    in_burst;

  assign in_burst  = (state_q == RD_BURST) || (state_q == WR_BURST);
  // Read data is always the registered buffer, so it stays put across write bursts.
  assign mem_rdata = rbuf_q;

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= 1'b0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rbuf_q  <= rbuf_d;
    end
  end

  // Next-state logic: latch the request in IDLE, step words on ack, pulse completion in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      IDLE: begin
        // Read takes priority if the cache ever raises both requests.
        if (mem_read) begin
          addr_d  = mem_addr;
          cnt_d   = '0;
          op_d    = 1'b0;
          state_d = RD_BURST;
        end else if (mem_write) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          cnt_d   = '0;
          op_d    = 1'b1;
          state_d = WR_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (dram_ack) begin
          if (!op_q) begin
            rbuf_d[{cnt_q, 5'd0} +: 32] = dram_rdata;
          end
          // The counter stays at the last index through DONE and clears on the way back to IDLE.
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs depend only on registered state, never on dram_ack.
  always_comb begin
    mem_ready  = 1'b0;
    dram_req   = 1'b0;
    dram_we    = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    if (in_burst) begin
      dram_req  = 1'b1;
      dram_we   = op_q;
      dram_addr = {addr_q, cnt_q};
      if (op_q) begin
        dram_wdata = wdata_q[{cnt_q, 5'd0} +: 32];
      end
    end
    if (state_q == DONE) begin
      mem_ready = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_burst_bridge.sv
// Directed bench for mem_burst_bridge: drives the cache and memory sides cycle by cycle.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_burst_bridge;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
  logic          dram_req;
  logic          dram_we;
  logic [29:0]   dram_addr;
  logic [31:0]   dram_wdata;
  logic [31:0]   dram_rdata;
  logic          dram_ack;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] RD1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] RD2 = 128'hA0000003_A0000002_A0000001_A0000000;
  localparam logic [127:0] RD3 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam logic [127:0] WD1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] WD2 = 128'h76543210_FEDCBA98_01234567_89ABCDEF;

  always #5 clk = ~clk;

  mem_burst_bridge #(.BLK_ADDR_W(28), .WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .dram_req   (dram_req),
    .dram_we    (dram_we),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .dram_ack   (dram_ack)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Runs nwords word transfers, each acked after 'waits' stall cycles.
  // Perturbs the cache inputs after the first word to show they are ignored.
  task automatic do_burst(input logic we, input logic [29:0] base, input int waits,
                          input int nwords, input logic [127:0] rwords,
                          input logic [127:0] wwords);
    for (int k = 0; k < nwords; k++) begin
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        chk("burst_req",   dram_req,   1'b1);
        chk("burst_we",    dram_we,    we);
        chk("burst_addr",  dram_addr,  base + 30'(k));
        chk("burst_wdata", dram_wdata, we ? wwords[32*k +: 32] : 32'h0);
        chk("burst_rdy",   mem_ready,  1'b0);
        if (k == 1 && w == 0) begin
          mem_addr  = ~mem_addr;
          mem_wdata = ~mem_wdata;
        end
        dram_ack   = (w == waits);
        dram_rdata = we ? 32'hDEADBEEF : rwords[32*k +: 32];
      end
    end
  endtask

  // Checks the completion cycle and drops the cache request as the cache would.
  task automatic finish_burst(input logic [127:0] exp_rd);
    @(negedge clk);
    dram_ack = 1'b0;
    chk("done_rdy",   mem_ready, 1'b1);
    chk("done_req",   dram_req,  1'b0);
    chk("done_rdata", mem_rdata, exp_rd);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    dram_rdata = '0;
    dram_ack   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy",   mem_ready,  1'b0);
    chk("rst_rdata", mem_rdata,  128'h0);
    chk("rst_req",   dram_req,   1'b0);
    chk("rst_we",    dram_we,    1'b0);
    chk("rst_addr",  dram_addr,  30'h0);
    chk("rst_wdata", dram_wdata, 32'h0);
    rst_n = 1'b1;

    // Zero-wait read of block 0x12 -> words 0x48..0x4B, ready at T+5
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = 28'h0000012;
    do_burst(1'b0, 30'h48, 0, 4, RD1, 128'h0);
    finish_burst(RD1);
    @(negedge clk);
    chk("pulse_rdy", mem_ready, 1'b0);
    chk("pulse_req", dram_req,  1'b0);

    // Write of block 3 with two wait cycles per word, ready at T+13, read data untouched
    mem_write = 1'b1;
    mem_addr  = 28'h3;
    mem_wdata = WD1;
    do_burst(1'b1, 30'hC, 2, 4, 128'h0, WD1);
    finish_burst(RD1);

    // Write-back of block 5, then refill of block 9 one IDLE cycle later
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 28'h5;
    mem_wdata = WD2;
    do_burst(1'b1, 30'h14, 0, 4, 128'h0, WD2);
    finish_burst(RD1);
    mem_read = 1'b1;
    mem_addr = 28'h9;
    @(negedge clk);
    chk("gap_req", dram_req,  1'b0);
    chk("gap_rdy", mem_ready, 1'b0);
    do_burst(1'b0, 30'h24, 0, 4, RD2, 128'h0);
    finish_burst(RD2);

    // Spurious ack in IDLE, then read and write raised together
    dram_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("spur_req",   dram_req,  1'b0);
      chk("spur_rdy",   mem_ready, 1'b0);
      chk("spur_rdata", mem_rdata, RD2);
    end
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 28'h7;
    mem_wdata = WD1;
    do_burst(1'b0, 30'h1C, 1, 4, RD3, 128'h0);
    finish_burst(RD3);

    // Reset in the middle of a read burst after two acks
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = 28'h20;
    do_burst(1'b0, 30'h80, 0, 2, RD1, 128'h0);
    @(negedge clk);
    chk("mid_addr", dram_addr, 30'h82);
    chk("mid_req",  dram_req,  1'b1);
    rst_n    = 1'b0;
    dram_ack = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_req",   dram_req,  1'b0);
    chk("abort_rdy",   mem_ready, 1'b0);
    chk("abort_rdata", mem_rdata, 128'h0);
    chk("abort_addr",  dram_addr, 30'h0);
    dram_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_req", dram_req,  1'b0);
      chk("after_rdy", mem_ready, 1'b0);
    end
    dram_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
